// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS fetch/decode slice.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } fetch_state_t;

  // Word offset of a branch immediate, as a 32-bit byte displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory request/acknowledge bus between the fetch stage and imem.
interface instr_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch_pc_next_logic.sv
// Combinational next-PC selection: jump > taken branch > sequential.
module pc_next_logic
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] jump_field,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic [31:0] jump_target;
  logic [31:0] branch_target;

  assign pc_plus4      = pc + 32'd4;
  assign jump_target   = {pc_plus4[31:28], jump_field, 2'b00};
  assign branch_target = pc_plus4 + branch_offset(branch_imm);

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, imem handshake, instruction register and retire counter.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_fetch_if.master        imem,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [31:0]          instr,
  output logic [5:0]           opcode,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  input  logic                 branch_taken,
  input  logic [15:0]          branch_imm,
  input  logic                 jump,
  output logic [31:0]          retired_cnt
);

  fetch_state_t state_reg;
  logic [31:0]  pc_reg;
  logic [31:0]  instr_reg;
  logic [31:0]  retired_cnt_reg;
  logic         valid_reg;
  logic [31:0]  next_pc;

  pc_next_logic u_pc_next (
    .pc           (pc_reg),
    .jump_field   (instr_reg[25:0]),
    .jump         (jump),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_FETCH;
      pc_reg          <= RESET_PC;
      instr_reg       <= 32'h0;
      retired_cnt_reg <= 32'h0;
      valid_reg       <= 1'b0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (imem.ack) begin
            instr_reg <= imem.rdata;
            valid_reg <= 1'b1;
            state_reg <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            pc_reg          <= next_pc;
            retired_cnt_reg <= retired_cnt_reg + 32'd1;
            valid_reg       <= 1'b0;
            state_reg       <= S_FETCH;
          end
        end
        default: begin
          state_reg <= S_FETCH;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Gated by rst so an in-flight request drops in the same instant reset rises.
  assign imem.req    = (state_reg == S_FETCH) && !rst;
  assign imem.addr   = pc_reg;
  assign instr_valid = valid_reg;
  assign instr       = instr_reg;
  assign opcode      = instr_reg[31:26];
  assign pc          = pc_reg;
  assign retired_cnt = retired_cnt_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch and its next-PC sub-module.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [31:0] retired_cnt;

  instr_fetch_if imem_bus ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (imem_bus),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .opcode       (opcode),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .retired_cnt  (retired_cnt)
  );

  // Standalone next-PC instance for the table vectors
  logic [31:0] t_pc, t_p4, t_next;
  logic [25:0] t_jf;
  logic        t_j, t_b;
  logic [15:0] t_imm;

  pc_next_logic u_pnl (
    .pc           (t_pc),
    .jump_field   (t_jf),
    .jump         (t_j),
    .branch_taken (t_b),
    .branch_imm   (t_imm),
    .pc_plus4     (t_p4),
    .next_pc      (t_next)
  );

  typedef struct {
    logic [31:0] pc;
    logic [25:0] jf;
    logic        j;
    logic        b;
    logic [15:0] imm;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[9];

  int checks   = 0;
  int failures = 0;
  logic [31:0] model_pc;
  logic [31:0] model_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h2400_0000;
  endfunction

  // Expected successor PC from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] w,
                                           input bit j, input bit b, input logic [15:0] imm);
    logic [31:0] seq;
    int          disp;
    seq = cur + 32'd4;
    if (j) return {seq[31:28], w[25:0], 2'b00};
    if (b) begin
      disp = int'($signed(imm)) * 4;
      return seq + 32'(disp);
    end
    return seq;
  endfunction

  task automatic run_instr(input int ack_dly, input int hold, input bit j, input bit b,
                           input logic [15:0] imm);
    logic [31:0] w;
    chk("fetch_req", 32'(imem_bus.req), 32'd1);
    chk("fetch_addr", imem_bus.addr, model_pc);
    chk("fetch_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < ack_dly; i++) begin
      imem_bus.ack = 1'b0;
      instr_ready  = 1'($urandom);
      jump         = 1'($urandom);
      branch_taken = 1'($urandom);
      tick();
      chk("wait_req", 32'(imem_bus.req), 32'd1);
    end
    w = mem_word(model_pc);
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = w;
    tick();
    imem_bus.ack = 1'b0;
    instr_ready  = 1'b0;
    chk("lat_valid", 32'(instr_valid), 32'd1);
    chk("lat_instr", instr, w);
    chk("lat_opcode", 32'(opcode), 32'(w[31:26]));
    chk("lat_pc", pc, model_pc);
    chk("lat_pc4", pc_plus4, model_pc + 32'd4);
    chk("lat_req", 32'(imem_bus.req), 32'd0);
    for (int i = 0; i < hold; i++) begin
      imem_bus.ack   = 1'($urandom);
      imem_bus.rdata = $urandom;
      jump           = 1'($urandom);
      branch_taken   = 1'($urandom);
      tick();
      chk("hold_instr", instr, w);
      chk("hold_pc", pc, model_pc);
      chk("hold_req", 32'(imem_bus.req), 32'd0);
    end
    imem_bus.ack = 1'b0;
    instr_ready  = 1'b1;
    jump         = j;
    branch_taken = b;
    branch_imm   = imm;
    tick();
    instr_ready  = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    model_pc  = ref_next(model_pc, w, j, b, imm);
    model_cnt = model_cnt + 32'd1;
    chk("ret_cnt", retired_cnt, model_cnt);
    chk("ret_valid", 32'(instr_valid), 32'd0);
    $display("retire #%0d next_pc=%h j=%0d b=%0d imm=%h", model_cnt, model_pc, j, b, imm);
  endtask

  initial begin
    logic [15:0] imm;
    rst = 1'b1;
    imem_bus.ack = 1'b0;
    imem_bus.rdata = 32'h0;
    instr_ready = 1'b0;
    jump = 1'b0;
    branch_taken = 1'b0;
    branch_imm = 16'h0;

    vecs[0] = '{32'h0000_0010, 26'h0, 1'b0, 1'b1, 16'hFFFC, 32'h0000_0004};
    vecs[1] = '{32'h0000_0010, 26'h0, 1'b0, 1'b1, 16'h0003, 32'h0000_0020};
    vecs[2] = '{32'h1000_0000, 26'h0000040, 1'b1, 1'b0, 16'h0000, 32'h1000_0100};
    vecs[3] = '{32'h1000_0000, 26'h0000040, 1'b1, 1'b1, 16'h0003, 32'h1000_0100};
    vecs[4] = '{32'hFFFF_FFFC, 26'h3FFFFFF, 1'b0, 1'b0, 16'h1234, 32'h0000_0000};
    vecs[5] = '{32'h0000_0010, 26'h0, 1'b0, 1'b1, 16'hFFFF, 32'h0000_0010};
    vecs[6] = '{32'h0000_0008, 26'h0, 1'b0, 1'b0, 16'hFFFC, 32'h0000_000C};
    vecs[7] = '{32'h0FFF_FFFC, 26'h0000001, 1'b1, 1'b0, 16'h0000, 32'h1000_0004};
    vecs[8] = '{32'h0000_0000, 26'h0, 1'b0, 1'b1, 16'hFFFE, 32'hFFFF_FFFC};
    foreach (vecs[k]) begin
      t_pc = vecs[k].pc; t_jf = vecs[k].jf; t_j = vecs[k].j; t_b = vecs[k].b; t_imm = vecs[k].imm;
      #1;
      chk($sformatf("pnl_vec%0d", k), t_next, vecs[k].exp_next);
      chk($sformatf("pnl_p4_%0d", k), t_p4, vecs[k].pc + 32'd4);
      $display("pnl vec %0d pc=%h next=%h", k, t_pc, t_next);
    end

    // Reset state
    repeat (2) tick();
    chk("rst_req", 32'(imem_bus.req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_cnt", retired_cnt, 32'h0);
    rst = 1'b0;
    #1;
    model_pc  = 32'h0;
    model_cnt = 32'h0;

    // Sequential fetches, then branches back and forward from 0x10
    run_instr(1, 0, 1'b0, 1'b0, 16'h0);
    run_instr(0, 0, 1'b0, 1'b0, 16'h0);
    run_instr(0, 1, 1'b0, 1'b0, 16'h0);
    chk("seq_addr_c", imem_bus.addr, 32'h0000_000C);
    chk("seq_cnt3", retired_cnt, 32'd3);
    run_instr(0, 0, 1'b0, 1'b0, 16'h0);
    run_instr(0, 0, 1'b0, 1'b1, 16'hFFFC);
    chk("br_back", imem_bus.addr, 32'h0000_0004);
    run_instr(0, 0, 1'b0, 1'b0, 16'h0);
    run_instr(0, 0, 1'b0, 1'b0, 16'h0);
    run_instr(0, 0, 1'b0, 1'b0, 16'h0);
    run_instr(2, 0, 1'b0, 1'b1, 16'h0003);
    chk("br_fwd", imem_bus.addr, 32'h0000_0020);
    run_instr(0, 0, 1'b0, 1'b1, 16'hFFFF);
    chk("br_same", imem_bus.addr, 32'h0000_0020);

    // Back-pressure with ack toggling while held
    run_instr(1, 5, 1'b0, 1'b0, 16'h0);

    // Branch back to 0, then below 0, then wrap forward to 0
    imm = 16'(-((model_pc + 32'd4) >> 2));
    run_instr(0, 0, 1'b0, 1'b1, imm);
    chk("to_zero", imem_bus.addr, 32'h0);
    run_instr(0, 0, 1'b0, 1'b1, 16'hFFFE);
    chk("to_top", imem_bus.addr, 32'hFFFF_FFFC);
    run_instr(0, 0, 1'b0, 1'b0, 16'h0);
    chk("wrap", imem_bus.addr, 32'h0);

    // Randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                16'($signed(int'($urandom_range(0, 16)) - 8)));
    end

    // Reset while a request is outstanding, ack arriving late
    tick();
    chk("pre_rst_req", 32'(imem_bus.req), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(imem_bus.req), 32'd0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_cnt", retired_cnt, 32'h0);
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = mem_word(32'h0);
    tick();
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_req", 32'(imem_bus.req), 32'd1);
    tick();
    imem_bus.ack = 1'b0;
    chk("late_ack_instr", instr, mem_word(32'h0));
    chk("late_ack_valid", 32'(instr_valid), 32'd1);
    chk("late_ack_pc", pc, 32'h0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("after_rst_cnt", retired_cnt, 32'd1);
    chk("after_rst_addr", imem_bus.addr, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
